// File: rtl/vga_pkg.sv
// vga_pkg: shared raster timing definitions for the display path.
//   - 640x480@60 timing constants (pixels / lines)
//   - derived totals and sync window bounds (start inclusive, end exclusive)
//   - 10-bit count type used for h/v positions
//   - wrap_inc helper for modulo position counters
package vga_pkg;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Increment with wrap to zero after the last valid position.
    function automatic cnt_t wrap_inc(input cnt_t x, input cnt_t last);
        return (x == last) ? '0 : cnt_t'(x + 1'b1);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the timing generator to
// downstream address generators.
//   pclk_en      1   strobe in first clk of each pixel
//   h_cnt/v_cnt  10  current raster position
//   hsync/vsync  1   active-low sync
//   valid        1   position is inside the visible area
//   frame_start  1   strobe when position becomes (0,0)
// Modports: master (generator side, drives), slave (consumer side, reads).
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic pclk_en;
    cnt_t h_cnt;
    cnt_t v_cnt;
    logic hsync;
    logic vsync;
    logic valid;
    logic frame_start;

    modport master (
        output pclk_en, h_cnt, v_cnt, hsync, vsync, valid, frame_start
    );

    modport slave (
        input pclk_en, h_cnt, v_cnt, hsync, vsync, valid, frame_start
    );

endinterface

// File: rtl/vga_timing_gen_pixel_tick_div.sv
// pixel_tick_div: rate strobe generator. Counts 0..DIV-1 on clk and
// raises tick combinationally on the last count, so tick is high one clk
// in every DIV. With DIV=1 the counter never leaves 0 and tick is always 1.
//   clk   in   system clock
//   rst   in   synchronous active-low reset (counter to 0)
//   tick  out  combinational strobe, (div == DIV-1)
module pixel_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] div;

    assign tick = (div == LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster position and sync generator.
// Advances one pixel per tick of the pixel divider; all outputs are
// registered from the next-state counter values so h/v, sync, valid and
// the strobes always describe the same pixel with no skew.
//   clk  in   system clock
//   rst  in   synchronous active-low reset; parks position at the last
//             pixel of the frame so the first tick lands on (0,0)
//   vo   master modport of vga_timing_gen_if (all raster outputs)
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int DIV      = 4,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  vo
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_LAST_C = cnt_t'(H_TOT - 1);
    localparam cnt_t V_LAST_C = cnt_t'(V_TOT - 1);
    localparam cnt_t H_ACT_C  = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT_C  = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_LO_C  = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_HI_C  = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS_LO_C  = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_HI_C  = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    logic tick;
    cnt_t h_cnt, v_cnt;
    cnt_t next_h, next_v;
    logic hsync, vsync, valid, pclk_en, frame_start;

    pixel_tick_div #(.DIV(DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        next_h = h_cnt;
        next_v = v_cnt;
        if (tick) begin
            next_h = wrap_inc(h_cnt, H_LAST_C);
            if (h_cnt == H_LAST_C) begin
                next_v = wrap_inc(v_cnt, V_LAST_C);
            end
        end
    end

    // Decode from next_h/next_v so the registered sync/valid line up with
    // the registered counters on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_cnt       <= H_LAST_C;
            v_cnt       <= V_LAST_C;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            valid       <= 1'b0;
            pclk_en     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_cnt       <= next_h;
            v_cnt       <= next_v;
            hsync       <= !((next_h >= HS_LO_C) && (next_h < HS_HI_C));
            vsync       <= !((next_v >= VS_LO_C) && (next_v < VS_HI_C));
            valid       <= (next_h < H_ACT_C) && (next_v < V_ACT_C);
            pclk_en     <= tick;
            frame_start <= tick && (next_h == '0) && (next_v == '0);
        end
    end

    assign vo.h_cnt       = h_cnt;
    assign vo.v_cnt       = v_cnt;
    assign vo.hsync       = hsync;
    assign vo.vsync       = vsync;
    assign vo.valid       = valid;
    assign vo.pclk_en     = pclk_en;
    assign vo.frame_start = frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Three instances share one clock:
//   dut_a  default 640x480 timing, DIV=4
//   dut_b  small timing, DIV=1 (full frames fit in a short run)
//   dut_c  small timing, DIV=3, hit with random resets
// The reference model derives every output from the number of clk edges
// seen with rst high since the last reset, using pixel-index arithmetic.
module tb_vga_timing_gen;

    localparam int DA = 4;
    localparam int AHA = 640, AHF = 16, AHS = 96, AHB = 48;
    localparam int AVA = 480, AVF = 10, AVS = 2,  AVB = 33;

    localparam int DB = 1;
    localparam int BHA = 20, BHF = 3, BHS = 4, BHB = 5;
    localparam int BVA = 12, BVF = 2, BVS = 2, BVB = 3;

    localparam int DC = 3;
    localparam int CHA = 10, CHF = 2, CHS = 3, CHB = 2;
    localparam int CVA = 6,  CVF = 1, CVS = 2, CVB = 2;

    // {pclk_en, frame_start, hsync, vsync, valid, h_cnt, v_cnt}
    localparam logic [24:0] RESET_A = {5'b00110, 10'd799, 10'd524};
    localparam logic [24:0] RESET_B = {5'b00110, 10'd31, 10'd18};
    localparam logic [24:0] RESET_C = {5'b00110, 10'd16, 10'd10};

    logic clk = 1'b0;
    logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
    int   e_a = 0, e_b = 0, e_c = 0;
    int   checks = 0, passes = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if ifa ();
    vga_timing_gen_if ifb ();
    vga_timing_gen_if ifc ();

    vga_timing_gen #(.DIV(DA), .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
                     .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB))
        dut_a (.clk(clk), .rst(rst_a), .vo(ifa));
    vga_timing_gen #(.DIV(DB), .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
                     .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB))
        dut_b (.clk(clk), .rst(rst_b), .vo(ifb));
    vga_timing_gen #(.DIV(DC), .H_ACTIVE(CHA), .H_FP(CHF), .H_SYNC(CHS), .H_BP(CHB),
                     .V_ACTIVE(CVA), .V_FP(CVF), .V_SYNC(CVS), .V_BP(CVB))
        dut_c (.clk(clk), .rst(rst_c), .vo(ifc));

    logic [24:0] obs_a, obs_b, obs_c;
    assign obs_a = {ifa.pclk_en, ifa.frame_start, ifa.hsync, ifa.vsync, ifa.valid, ifa.h_cnt, ifa.v_cnt};
    assign obs_b = {ifb.pclk_en, ifb.frame_start, ifb.hsync, ifb.vsync, ifb.valid, ifb.h_cnt, ifb.v_cnt};
    assign obs_c = {ifc.pclk_en, ifc.frame_start, ifc.hsync, ifc.vsync, ifc.valid, ifc.h_cnt, ifc.v_cnt};

    // Edges with rst high since the last reset edge.
    always @(posedge clk) begin
        e_a <= rst_a ? e_a + 1 : 0;
        e_b <= rst_b ? e_b + 1 : 0;
        e_c <= rst_c ? e_c + 1 : 0;
    end

    function automatic logic [24:0] model(input int div, input int ha, input int hfp,
                                          input int hs, input int hbp, input int va,
                                          input int vfp, input int vs, input int vbp,
                                          input int e);
        int ht, vt, tot, ticks, pos, h, v;
        logic pe, fs, hsy, vsy, vl;
        ht = ha + hfp + hs + hbp;
        vt = va + vfp + vs + vbp;
        tot = ht * vt;
        ticks = e / div;
        if (ticks == 0)
            return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'(ht - 1), 10'(vt - 1)};
        // Reset parks at the last pixel, so tick n lands on pixel index n-1.
        pos = (tot - 1 + ticks) % tot;
        h = pos % ht;
        v = pos / ht;
        pe = (e % div) == 0;
        fs = pe && (pos == 0);
        hsy = !((h >= ha + hfp) && (h < ha + hfp + hs));
        vsy = !((v >= va + vfp) && (v < va + vfp + vs));
        vl = (h < ha) && (v < va);
        return {pe, fs, hsy, vsy, vl, 10'(h), 10'(v)};
    endfunction

    function automatic logic [24:0] exp_a();
        return model(DA, AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB, e_a);
    endfunction
    function automatic logic [24:0] exp_b();
        return model(DB, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, e_b);
    endfunction
    function automatic logic [24:0] exp_c();
        return model(DC, CHA, CHF, CHS, CHB, CVA, CVF, CVS, CVB, e_c);
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs_a !== exp_a()) $display("FAIL reset_model_a: got %h expected %h", obs_a, exp_a());
            else passes++;
        end
        checks++;
        if (obs_a !== RESET_A) $display("FAIL reset_a: got %h expected %h", obs_a, RESET_A);
        else passes++;
        checks++;
        if (obs_b !== RESET_B) $display("FAIL reset_b: got %h expected %h", obs_b, RESET_B);
        else passes++;
        checks++;
        if (obs_c !== RESET_C) $display("FAIL reset_c: got %h expected %h", obs_c, RESET_C);
        else passes++;
    endtask

    task automatic test_startup();
        rst_a = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            checks++;
            if (obs_a !== exp_a()) $display("FAIL startup_model cyc %0d: got %h expected %h", i, obs_a, exp_a());
            else passes++;
            if (i == 3) begin
                checks++;
                if (obs_a !== RESET_A) $display("FAIL startup_hold: got %h expected %h", obs_a, RESET_A);
                else passes++;
            end
            if (i == 4) begin
                checks++;
                if (obs_a !== {5'b11111, 10'd0, 10'd0})
                    $display("FAIL startup_first_tick: got %h expected %h", obs_a, {5'b11111, 10'd0, 10'd0});
                else passes++;
            end
            if (i == 5) begin
                checks++;
                if (obs_a !== {5'b00111, 10'd0, 10'd0})
                    $display("FAIL startup_pulse_width: got %h expected %h", obs_a, {5'b00111, 10'd0, 10'd0});
                else passes++;
            end
            if (i == 8) begin
                checks++;
                if (obs_a !== {5'b10111, 10'd1, 10'd0})
                    $display("FAIL startup_second_tick: got %h expected %h", obs_a, {5'b10111, 10'd1, 10'd0});
                else passes++;
            end
        end
    endtask

    task automatic test_line();
        int   n_sync = 0;
        logic saw_wrap = 1'b0, saw_fall = 1'b0;
        logic prev_valid;
        logic [9:0] prev_h, prev_v;
        prev_valid = ifa.valid; prev_h = ifa.h_cnt; prev_v = ifa.v_cnt;
        repeat (3300) begin
            @(negedge clk);
            checks++;
            if (obs_a !== exp_a()) $display("FAIL line_model e=%0d: got %h expected %h", e_a, obs_a, exp_a());
            else passes++;
            if (ifa.pclk_en && !ifa.hsync && ifa.v_cnt == 10'd0) n_sync++;
            if (prev_valid && !ifa.valid) begin
                saw_fall = 1'b1;
                checks++;
                if (ifa.h_cnt !== 10'd640) $display("FAIL valid_fall_h: got %0d expected 640", ifa.h_cnt);
                else passes++;
            end
            if (prev_h == 10'd799 && ifa.h_cnt == 10'd0) begin
                saw_wrap = 1'b1;
                checks++;
                if (ifa.v_cnt !== prev_v + 10'd1) $display("FAIL h_wrap_v: got %0d expected %0d", ifa.v_cnt, prev_v + 10'd1);
                else passes++;
            end
            prev_valid = ifa.valid; prev_h = ifa.h_cnt; prev_v = ifa.v_cnt;
        end
        checks++;
        if (n_sync != AHS) $display("FAIL hsync_width: got %0d expected %0d", n_sync, AHS);
        else passes++;
        checks++;
        if (!(saw_wrap && saw_fall)) $display("FAIL line_events: got wrap=%0b fall=%0b expected 1 1", saw_wrap, saw_fall);
        else passes++;
    endtask

    task automatic test_mid_reset();
        int n;
        repeat (3) begin
            n = int'($urandom_range(100, 2500));
            repeat (n) begin
                @(negedge clk);
                checks++;
                if (obs_a !== exp_a()) $display("FAIL midrst_run e=%0d: got %h expected %h", e_a, obs_a, exp_a());
                else passes++;
            end
            rst_a = 1'b0;
            @(negedge clk);
            checks++;
            if (obs_a !== RESET_A) $display("FAIL midrst_restore: got %h expected %h", obs_a, RESET_A);
            else passes++;
            rst_a = 1'b1;
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                checks++;
                if (obs_a !== exp_a()) $display("FAIL midrst_after cyc %0d: got %h expected %h", i, obs_a, exp_a());
                else passes++;
                if (i == DA) begin
                    checks++;
                    if (obs_a !== {5'b11111, 10'd0, 10'd0})
                        $display("FAIL midrst_frame_start: got %h expected %h", obs_a, {5'b11111, 10'd0, 10'd0});
                    else passes++;
                end
            end
        end
    endtask

    task automatic test_div1_frame();
        localparam int HT = BHA + BHF + BHS + BHB;
        localparam int VT = BVA + BVF + BVS + BVB;
        int last_fs = -1, nfs = 0;
        rst_b = 1'b1;
        for (int cyc = 1; cyc <= 3 * HT * VT + 20; cyc++) begin
            @(negedge clk);
            checks++;
            if (obs_b !== exp_b()) $display("FAIL div1_model e=%0d: got %h expected %h", e_b, obs_b, exp_b());
            else passes++;
            checks++;
            if (ifb.pclk_en !== 1'b1) $display("FAIL div1_pclk_en cyc %0d: got %b expected 1", cyc, ifb.pclk_en);
            else passes++;
            if (!ifb.vsync) begin
                checks++;
                if (!(int'(ifb.v_cnt) >= BVA + BVF && int'(ifb.v_cnt) < BVA + BVF + BVS))
                    $display("FAIL div1_vsync_line: got v=%0d expected %0d..%0d", ifb.v_cnt, BVA + BVF, BVA + BVF + BVS - 1);
                else passes++;
            end
            if (ifb.frame_start) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (cyc - last_fs != HT * VT) $display("FAIL div1_frame_period: got %0d expected %0d", cyc - last_fs, HT * VT);
                    else passes++;
                end
                last_fs = cyc;
                nfs++;
            end
        end
        checks++;
        if (nfs != 4) $display("FAIL div1_frame_count: got %0d expected 4", nfs);
        else passes++;
    endtask

    task automatic test_random_reset();
        int n, r;
        rst_c = 1'b1;
        repeat (15) begin
            n = int'($urandom_range(1, 1200));
            repeat (n) begin
                @(negedge clk);
                checks++;
                if (obs_c !== exp_c()) $display("FAIL rndrst_run e=%0d: got %h expected %h", e_c, obs_c, exp_c());
                else passes++;
            end
            r = int'($urandom_range(1, 3));
            rst_c = 1'b0;
            repeat (r) begin
                @(negedge clk);
                checks++;
                if (obs_c !== RESET_C) $display("FAIL rndrst_hold: got %h expected %h", obs_c, RESET_C);
                else passes++;
            end
            rst_c = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_line();
        test_mid_reset();
        test_div1_frame();
        test_random_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream raster source for the display path. Produces the 10-bit h_cnt/v_cnt consumed by the sprite/number address generators, plus sync and video-valid.
- Runs on the single system clock clk (100 MHz) and advances one pixel every DIV clocks (25 MHz pixel rate at default).
- Standard 640x480@60 timing at defaults. All counter and sync outputs are registered and mutually aligned, so downstream address math sees glitch-free, consistent values.

Parameters:
- DIV, 4, clk cycles per pixel (1..16); DIV=1 advances every clk.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BP, 33, vertical back porch (lines).
- Derived: H_TOTAL = sum of H_* = 800; V_TOTAL = sum of V_* = 525. Both must be ≤1024.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- pclk_en  out  1  one-clk pulse in the first clk cycle of each new pixel.
- h_cnt  out  10  horizontal position, 0..H_TOTAL-1.
- v_cnt  out  10  vertical position, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync, active-low.
- vsync  out  1  vertical sync, active-low.
- valid  out  1  high when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- frame_start  out  1  one-clk pulse coincident with pclk_en when counters become (0,0).

Behaviour:
- Reset (rst==0 at a clk edge):
  - div counter=0, h_cnt=H_TOTAL-1 (799), v_cnt=V_TOTAL-1 (524).
  - hsync=1, vsync=1, valid=0, pclk_en=0, frame_start=0.
  - Reset overrides everything, including mid-line or mid-frame; no partial state survives.
- Divider:
  - div counts 0..DIV-1 and wraps to 0.
  - tick is internal and combinational: tick = (div==DIV-1).
  - With DIV=1, tick is constantly 1.
- Counter advance, at a clk edge where tick=1:
  - h_cnt <= (h_cnt==H_TOTAL-1) ? 0 : h_cnt+1.
  - v_cnt increments only when h_cnt wraps: v_cnt <= (v_cnt==V_TOTAL-1) ? 0 : v_cnt+1.
  - Both wraps together give the (799,524) -> (0,0) frame wrap.
- Derived outputs:
  - Computed from the next-state counter values and registered on the same edge, so they are always consistent with the current h_cnt/v_cnt. There is no pipeline skew.
  - hsync=0 iff H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync=0 iff V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
  - valid as defined in Ports.
  - pclk_en <= tick, so it is high in the clk cycle following the update.
  - frame_start <= tick && next_h==0 && next_v==0.
- Hold: outputs are stable between ticks; h_cnt/v_cnt change only on tick edges.
- Start-up and latency:
  - The first tick after reset release moves (799,524) -> (0,0), with valid=1 and frame_start=1.
  - That tick occurs DIV clk edges after the first edge with rst==1.
- Widths: counters are 10-bit unsigned, with no overflow because totals are ≤1024. Comparisons are unsigned against 10-bit constants.

Decomposition:
- Package vga_pkg holds:
  - the 640x480@60 timing constants;
  - the derived H_TOTAL, V_TOTAL, H_SYNC_START, H_SYNC_END, V_SYNC_START, V_SYNC_END;
  - the 10-bit count type width.
- Sub-module pixel_tick_div (parameter DIV; ports clk, rst, tick) owns the divider. The same sub-module is reusable for other rate strobes.
- vga_timing_gen owns the counters and the registered decode.

Test Plan:
- Hold rst=0 for 3 clks -> h_cnt=799, v_cnt=524, hsync=1, vsync=1, valid=0, pclk_en=0, frame_start=0.
- Release rst at DIV=4 -> on the 4th edge h_cnt=0, v_cnt=0, valid=1; frame_start and pclk_en pulse for exactly 1 clk; the next change is 4 clks later to h_cnt=1.
- Run one full line -> hsync low for exactly 96 pixels, from h=656 through h=751; valid falls at h=640; h wraps at 799 to 0 with v_cnt 0->1.
- Run one full frame -> vsync low only on lines 490-491; v wraps at 524 to 0; frame_start pulses once per 800*525*4 = 1,680,000 clks.
- Assert rst=0 for 1 clk mid-frame (e.g. h=300, v=200) -> next edge restores the reset values; the first subsequent tick again yields (0,0) with frame_start.
- Instantiate with DIV=1 -> pclk_en is constant 1 after reset; h_cnt increments every clk; frame period is 420,000 clks.
